fft_digit_reverse_buffer: RTL



---
 rtl/fft_pkg.sv | 43 ++++
 rtl/fft_digit_reverse_buffer_if.sv | 35 +++
 rtl/fft_pingpong_ram.sv | 28 ++
 rtl/fft_digit_reverse_buffer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT helpers (digit reversal, base-4 log), read-side state type.
// No ports; imported by the reorder buffer and the SDF stages.
package fft_pkg;

  localparam int N_DEFAULT = 16;
  localparam int ADDR_W = $clog2(N_DEFAULT);

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // Number of base-4 digits needed to index n points.
  function automatic int unsigned clog4(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    for (int unsigned i = 0; i < 15; i++) begin
      if (v < n) begin
        v = v << 2;
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Reverse the order of the low m base-4 digits of idx.
  function automatic int unsigned digit_rev(
    input int unsigned idx,
    input int unsigned m
  );
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < m) begin
        r = (r << 2) | ((idx >> (2 * i)) & 32'd3);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_digit_reverse_buffer_if.sv
// Sample stream bundle for the reorder buffer: input samples in, bins out.
// master = upstream/sink side, slave = the buffer itself.
interface fft_digit_reverse_buffer_if #(
  parameter int WIDTH = 32
);

  logic             input_en;
  logic [WIDTH-1:0] input_real;
  logic [WIDTH-1:0] input_imag;
  logic             output_en;
  logic [WIDTH-1:0] output_real;
  logic [WIDTH-1:0] output_imag;
  logic             output_last;

  modport master (
    output input_en,
    output input_real,
    output input_imag,
    input  output_en,
    input  output_real,
    input  output_imag,
    input  output_last
  );

  modport slave (
    input  input_en,
    input  input_real,
    input  input_imag,
    output output_en,
    output output_real,
    output output_imag,
    output output_last
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of DEPTH words, one sync write port
// (wr_bank/wr_addr/wr_data), one async read port (rd_bank/rd_addr/rd_data).
module fft_pingpong_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_digit_reverse_buffer.sv
// fft_digit_reverse_buffer: reorders base-4 digit-reversed SDF frames to natural order.
// Ports: clock, reset_n (async low), io (input_* samples in, output_* bins out).
module fft_digit_reverse_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int Num_of_samples = 16
) (
  input logic                        clock,
  input logic                        reset_n,
  fft_digit_reverse_buffer_if.slave  io
);

  localparam int N = Num_of_samples;
  localparam int AW = $clog2(N);
  localparam int unsigned M = clog4(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  if ((N < 4) || ((1 << (2 * M)) != N)) begin : g_bad_n
    $error("Num_of_samples must be a power of 4 and >= 4");
  end

  logic            wr_bank;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   wr_addr;
  logic            frame_done;

  rd_state_e       state;
  rd_state_e       state_n;
  logic            rd_bank;
  logic            rd_bank_n;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   rd_idx_n;
  logic            rd_act;
  logic            rd_last;
  logic [2*WIDTH-1:0] rd_data;

  assign frame_done = io.input_en && (wr_idx == LAST);
  assign wr_addr = AW'(digit_rev(32'(wr_idx), M));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (io.input_en) begin
      wr_idx <= wr_idx + 1'b1;
      if (wr_idx == LAST) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  fft_pingpong_ram #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (N),
    .AW     (AW)
  ) u_ram (
    .clock   (clock),
    .we      (io.input_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({io.input_real, io.input_imag}),
    .rd_bank (rd_bank),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      state   <= state_n;
      rd_bank <= rd_bank_n;
      rd_idx  <= rd_idx_n;
    end
  end

  // A frame finishing on the last read cycle chains straight
  // into the next read, keeping the output gapless.
  always_comb begin
    state_n   = state;
    rd_bank_n = rd_bank;
    rd_idx_n  = rd_idx;
    unique case (state)
      RD_IDLE: begin
        if (frame_done) begin
          state_n   = RD_READ;
          rd_bank_n = wr_bank;
          rd_idx_n  = '0;
        end
      end
      RD_READ: begin
        rd_idx_n = rd_idx + 1'b1;
        if (rd_idx == LAST) begin
          rd_idx_n = '0;
          if (frame_done) begin
            rd_bank_n = wr_bank;
          end else begin
            state_n = RD_IDLE;
          end
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_act  = (state == RD_READ);
    rd_last = rd_act && (rd_idx == LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io.output_en   <= 1'b0;
      io.output_last <= 1'b0;
      io.output_real <= '0;
      io.output_imag <= '0;
    end else begin
      io.output_en   <= rd_act;
      io.output_last <= rd_last;
      if (rd_act) begin
        io.output_real <= rd_data[2*WIDTH-1:WIDTH];
        io.output_imag <= rd_data[WIDTH-1:0];
      end
    end
  end

endmodule
